// File: rtl/riscv_pkg.sv
// riscv_pkg: FSM states, opcode constants, instruction field positions and decode record for instr_ctrl
package riscv_pkg;
    typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, HALT} state_t;
    localparam logic [6:0]  OP_RTYPE = 7'b0110011;
    localparam logic [31:0] ECALL    = 32'h00000073;
    localparam int OPC_LSB = 0;
    localparam int RD_LSB  = 7;
    localparam int F3_LSB  = 12;
    localparam int RS1_LSB = 15;
    localparam int RS2_LSB = 20;
    localparam int F7_ALT  = 30;
    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic [3:0] op;
        logic       wr;
        logic       ecall;
    } dec_t;
endpackage

// File: rtl/instr_decode.sv
// instr_decode: combinational field extraction and classification of one instruction word
module instr_decode
    import riscv_pkg::*;
(
    input  logic [31:0] instr,
    output dec_t        dec
);
    always_comb begin
        dec.rs1   = instr[RS1_LSB +: 5];
        dec.rs2   = instr[RS2_LSB +: 5];
        dec.rd    = instr[RD_LSB +: 5];
        dec.op    = {instr[F7_ALT], instr[F3_LSB +: 3]};
        dec.wr    = instr[OPC_LSB +: 7] == OP_RTYPE && instr[RD_LSB +: 5] != 5'd0;
        dec.ecall = instr == ECALL;
    end
endmodule

// File: rtl/instr_ctrl.sv
// instr_ctrl: multi-cycle fetch/decode/execute controller; define INSTR_CTRL_INSTRET_EN to enable the instret counter
module instr_ctrl
    import riscv_pkg::*;
#(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         reset,
    output logic         imem_req,
    output logic [N-1:0] imem_addr,
    input  logic         imem_ack,
    input  logic [N-1:0] imem_rdata,
    input  logic         zero_f,
    output logic [4:0]   read_add1,
    output logic [4:0]   read_add2,
    output logic [4:0]   write_add,
    output logic [3:0]   OpCode,
    output logic         write_en,
    output logic         halted,
    output logic         last_zero,
    output logic [31:0]  instret
);
    state_t       state;
    logic [N-1:0] pc;
    logic [N-1:0] ir;
    logic [31:0]  dec_in;
    dec_t         dec;
    // decode the bus word during FETCH so the fields are already registered when DECODE begins
    assign dec_in    = state == FETCH ? imem_rdata[31:0] : ir[31:0];
    assign imem_addr = pc;
    instr_decode u_decode (
        .instr(dec_in),
        .dec  (dec)
    );
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            pc        <= '0;
            ir        <= '0;
            imem_req  <= 1'b0;
            read_add1 <= '0;
            read_add2 <= '0;
            write_add <= '0;
            OpCode    <= '0;
            write_en  <= 1'b0;
            halted    <= 1'b0;
            last_zero <= 1'b0;
        end else begin
            write_en <= 1'b0;
            case (state)
                IDLE: begin
                    state    <= FETCH;
                    imem_req <= 1'b1;
                end
                FETCH: if (imem_ack) begin
                    state     <= DECODE;
                    imem_req  <= 1'b0;
                    ir        <= imem_rdata;
                    read_add1 <= dec.rs1;
                    read_add2 <= dec.rs2;
                    write_add <= dec.rd;
                    OpCode    <= dec.op;
                end
                DECODE: begin
                    state    <= EXEC;
                    write_en <= dec.wr;
                end
                EXEC: begin
                    last_zero <= zero_f;
                    state     <= dec.ecall ? HALT : FETCH;
                    imem_req  <= !dec.ecall;
                    halted    <= dec.ecall;
                    pc        <= dec.ecall ? pc : pc + N'(4);
                end
                default: ;
            endcase
        end
    end
`ifdef INSTR_CTRL_INSTRET_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) instret <= '0;
        else if (state == EXEC) instret <= instret + 32'd1;
    end
`else
    assign instret = '0;
`endif
endmodule

// File: tb/tb_instr_ctrl.sv
// tb_instr_ctrl: randomized memory responder with an instruction-level reference model and a scoreboard monitor
module tb_instr_ctrl;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        zero_f = 1'b0;
    logic [4:0]  read_add1, read_add2, write_add;
    logic [3:0]  OpCode;
    logic        write_en, halted, last_zero;
    logic [31:0] instret;
    int n_err = 0;
    int n_chk = 0;
    logic [31:0] mem [0:63];
    int          dly [0:63];
    typedef struct {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic [3:0] op;
        bit         we;
        bit         ecall;
    } exp_t;
    exp_t q[$];

    always #5 clk = ~clk;

    instr_ctrl #(.N(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .imem_req  (imem_req),
        .imem_addr (imem_addr),
        .imem_ack  (imem_ack),
        .imem_rdata(imem_rdata),
        .zero_f    (zero_f),
        .read_add1 (read_add1),
        .read_add2 (read_add2),
        .write_add (write_add),
        .OpCode    (OpCode),
        .write_en  (write_en),
        .halted    (halted),
        .last_zero (last_zero),
        .instret   (instret)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    task automatic chk1(input string name, input logic got, input logic want);
        chk(name, {31'b0, got}, {31'b0, want});
    endtask

    function automatic exp_t model(input logic [31:0] w);
        exp_t e;
        e.rs1   = 5'((w >> 15) % 32);
        e.rs2   = 5'((w >> 20) % 32);
        e.rd    = 5'((w >> 7) % 32);
        e.op    = 4'(((w >> 30) % 2) * 8 + (w >> 12) % 8);
        e.we    = (w % 128 == 32'h33) && ((w >> 7) % 32 != 0);
        e.ecall = w == 32'h73;
        return e;
    endfunction

    function automatic logic [31:0] exp_instret(input int r);
`ifdef INSTR_CTRL_INSTRET_EN
        return 32'(r);
`else
        return (r < 0) ? 32'd1 : 32'd0;
`endif
    endfunction

    // memory responder: pushes the expected decode of every word it hands over
    initial begin
        int stall;
        logic [31:0] mpc;
        stall = 0;
        mpc = '0;
        forever begin
            @(posedge clk);
            #1;
            if (reset) begin
                stall = 0;
                mpc = '0;
                imem_ack = 1'b0;
            end else if (imem_req) begin
                if (stall < dly[mpc[7:2]]) begin
                    stall++;
                    imem_ack = 1'b0;
                    imem_rdata = $urandom;
                end else begin
                    imem_ack = 1'b1;
                    imem_rdata = mem[mpc[7:2]];
                    q.push_back(model(imem_rdata));
                    stall = 0;
                    mpc = (imem_rdata == 32'h73) ? mpc : mpc + 32'd4;
                end
            end else begin
                imem_ack = 1'($urandom % 2);
                imem_rdata = $urandom;
            end
            zero_f = 1'($urandom % 2);
        end
    end

    // monitor: tracks fetch/decode/exec from the DUT outputs and compares against the queue
    initial begin
        int mph;
        int retired;
        bit post, hlt, zf;
        logic [31:0] mpc;
        exp_t cur;
        mph = 0; retired = 0; post = 0; hlt = 0; zf = 0; mpc = '0;
        cur = model(32'h13);
        forever begin
            @(negedge clk);
            if (reset) begin
                mph = 0; retired = 0; post = 0; hlt = 0; mpc = '0;
            end else begin
                if (post) begin
                    post = 0;
                    chk1("last_zero", last_zero, zf);
                    chk("instret", instret, exp_instret(retired));
                    chk1("halted_after_exec", halted, cur.ecall);
                    chk1("req_after_exec", imem_req, !cur.ecall);
                end
                if (hlt) begin
                    chk1("halt_req", imem_req, 1'b0);
                    chk1("halt_we", write_en, 1'b0);
                    chk1("halt_flag", halted, 1'b1);
                    chk("halt_pc", imem_addr, mpc);
                end else if (mph == 0) begin
                    if (imem_req) begin
                        chk("fetch_addr", imem_addr, mpc);
                        chk1("fetch_we", write_en, 1'b0);
                        if (imem_ack) mph = 1;
                    end
                end else if (mph == 1) begin
                    if (q.size() == 0) begin
                        n_chk++;
                        n_err++;
                        $display("FAIL decode_queue: got empty want one entry");
                        mph = 0;
                    end else begin
                        cur = q.pop_front();
                        chk("dec_rs1", 32'(read_add1), 32'(cur.rs1));
                        chk("dec_rs2", 32'(read_add2), 32'(cur.rs2));
                        chk("dec_rd", 32'(write_add), 32'(cur.rd));
                        chk("dec_op", 32'(OpCode), 32'(cur.op));
                        chk1("dec_we", write_en, 1'b0);
                        chk1("dec_req", imem_req, 1'b0);
                        mph = 2;
                    end
                end else begin
                    chk("exec_rs1", 32'(read_add1), 32'(cur.rs1));
                    chk("exec_rs2", 32'(read_add2), 32'(cur.rs2));
                    chk("exec_rd", 32'(write_add), 32'(cur.rd));
                    chk("exec_op", 32'(OpCode), 32'(cur.op));
                    chk1("exec_we", write_en, cur.we);
                    chk1("exec_req", imem_req, 1'b0);
                    zf = zero_f;
                    retired++;
                    post = 1;
                    hlt = cur.ecall;
                    mph = 0;
                    if (!cur.ecall) mpc = mpc + 32'd4;
                end
            end
        end
    end

    task automatic reset_check(input string tag);
        chk1({tag, "_req"}, imem_req, 1'b0);
        chk({tag, "_addr"}, imem_addr, 32'd0);
        chk({tag, "_ra1"}, 32'(read_add1), 32'd0);
        chk({tag, "_ra2"}, 32'(read_add2), 32'd0);
        chk({tag, "_wa"}, 32'(write_add), 32'd0);
        chk({tag, "_op"}, 32'(OpCode), 32'd0);
        chk1({tag, "_we"}, write_en, 1'b0);
        chk1({tag, "_halted"}, halted, 1'b0);
        chk1({tag, "_lz"}, last_zero, 1'b0);
        chk({tag, "_instret"}, instret, 32'd0);
    endtask

    task automatic assert_reset();
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
    endtask

    task automatic release_reset();
        q.delete();
        @(negedge clk);
        #2 reset = 1'b0;
    endtask

    task automatic run_to_halt(input string tag, input int budget);
        int k;
        k = 0;
        while (!halted && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk1({tag, "_halt_reached"}, halted, 1'b1);
        chk({tag, "_queue_drained"}, 32'(q.size()), 32'd0);
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 64; i++) begin
            mem[i] = 32'h00000013;
            dly[i] = 0;
        end
    endtask

    initial begin
        logic [31:0] w;
        clear_prog();
        repeat (3) @(negedge clk);
        reset_check("por");
        // directed head, random body, ECALL at word 44
        mem[0] = 32'h002081B3;
        mem[1] = 32'h407302B3;
        mem[2] = 32'h00208033;
        mem[3] = 32'h00100093;
        dly[1] = 3;
        for (int i = 4; i < 44; i++) begin
            w = $urandom;
            if ($urandom % 2 == 1) w[6:0] = 7'h33;
            else if (w[6:0] == 7'h33) w[6:0] = 7'h13;
            if (w == 32'h73) w = 32'h13;
            mem[i] = w;
            dly[i] = int'($urandom % 4);
        end
        mem[44] = 32'h00000073;
        release_reset();
        run_to_halt("rand", 2000);
        chk("rand_halt_pc", imem_addr, 32'd176);
        repeat (20) @(negedge clk);
        chk1("rand_still_halted", halted, 1'b1);
        assert_reset();
        reset_check("rst_after_rand");

        clear_prog();
        mem[0] = 32'h002081B3;
        mem[1] = 32'h407302B3;
        mem[2] = 32'h00000073;
        release_reset();
        run_to_halt("ecall8", 200);
        chk("ecall8_pc", imem_addr, 32'd8);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk1("ecall8_req_low", imem_req, 1'b0);
        end
        chk("ecall8_pc_hold", imem_addr, 32'd8);
        assert_reset();
        reset_check("rst_after_halt");

        clear_prog();
        mem[0] = 32'h002081B3;
        mem[1] = 32'h00000073;
        dly[0] = 1000;
        release_reset();
        for (int k = 0; k < 10 && !imem_req; k++) @(negedge clk);
        chk1("midfetch_req_up", imem_req, 1'b1);
        repeat (2) @(negedge clk);
        assert_reset();
        chk1("midfetch_req_drop", imem_req, 1'b0);
        reset_check("midfetch");
        dly[0] = 0;
        release_reset();
        for (int k = 0; k < 10 && !imem_req; k++) @(negedge clk);
        chk1("refetch_req", imem_req, 1'b1);
        chk("refetch_addr", imem_addr, 32'd0);
        run_to_halt("refetch", 200);
        chk("refetch_halt_pc", imem_addr, 32'd4);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end
endmodule
